// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared types and defaults for the memory-side request arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arbiter_pkg;

    typedef logic [31:0]  pptr_t;
    typedef logic [127:0] cacheline_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ISSUE = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        IC = 1'b0,
        DC = 1'b1
    } client_t;

    localparam int c_DEFAULT_LATENCY = 5;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_rr_arbiter2.sv
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-way round-robin grant; ties go to the client not granted last.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter2
    import mem_arbiter_pkg::*;
(
    input  logic       i_ic_req,
    input  logic       i_dc_req,
    input  client_t    i_last_grant,
    output logic [1:0] o_grant
);

    // o_grant[0] = IC, o_grant[1] = DC
    always_comb begin
        o_grant = 2'b00;
        if (i_ic_req && i_dc_req) begin
            o_grant = (i_last_grant == IC) ? 2'b10 : 2'b01;
        end else begin
            o_grant = {i_dc_req, i_ic_req};
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Serialises icache/dcache line requests onto one memory port
//               with a programmable access latency; one transaction in flight.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int LATENCY = c_DEFAULT_LATENCY,
    parameter int CNT_W   = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ic_req_valid,
    input  pptr_t      ic_req_addr,
    output logic       ic_req_ready,
    output logic       ic_rsp_valid,
    output pptr_t      ic_rsp_addr,
    output cacheline_t ic_rsp_line,
    input  logic       dc_req_valid,
    input  logic       dc_req_we,
    input  pptr_t      dc_req_addr,
    input  cacheline_t dc_req_wline,
    output logic       dc_req_ready,
    output logic       dc_rsp_valid,
    output pptr_t      dc_rsp_addr,
    output cacheline_t dc_rsp_line,
    output logic       mem_ren,
    output pptr_t      mem_raddr,
    output logic       mem_wen,
    output pptr_t      mem_waddr,
    output cacheline_t mem_wline,
    input  logic       mem_rec_en,
    input  pptr_t      mem_rec_addr,
    input  cacheline_t mem_rec_line,
    output logic       err
);

    localparam logic [CNT_W-1:0] c_CNT_INIT = (LATENCY == 0) ? '0 : CNT_W'(LATENCY - 1);

    arb_state_t       r_state;
    arb_state_t       w_state_next;
    client_t          r_last_grant;
    client_t          r_client;
    logic             r_we;
    pptr_t            r_addr;
    cacheline_t       r_wline;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       w_grant;
    logic             r_ic_rsp_valid;
    pptr_t            r_ic_rsp_addr;
    cacheline_t       r_ic_rsp_line;
    logic             r_dc_rsp_valid;
    pptr_t            r_dc_rsp_addr;
    cacheline_t       r_dc_rsp_line;
    logic             r_err;

    rr_arbiter2 u_rr (
        .i_ic_req     (ic_req_valid),
        .i_dc_req     (dc_req_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        ic_req_ready = 1'b0;
        dc_req_ready = 1'b0;
        mem_ren      = 1'b0;
        mem_wen      = 1'b0;
        case (r_state)
            IDLE: begin
                ic_req_ready = w_grant[0];
                dc_req_ready = w_grant[1];
                if (w_grant != 2'b00) begin
                    w_state_next = (LATENCY == 0) ? ISSUE : WAIT;
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_state_next = ISSUE;
                end
            end
            ISSUE: begin
                mem_ren      = !r_we;
                mem_wen      = r_we;
                w_state_next = r_we ? IDLE : RESP;
            end
            RESP: begin
                if (mem_rec_en) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt          <= '0;
            r_last_grant   <= IC;
            r_client       <= IC;
            r_we           <= 1'b0;
            r_addr         <= '0;
            r_wline        <= '0;
            r_ic_rsp_valid <= 1'b0;
            r_ic_rsp_addr  <= '0;
            r_ic_rsp_line  <= '0;
            r_dc_rsp_valid <= 1'b0;
            r_dc_rsp_addr  <= '0;
            r_dc_rsp_line  <= '0;
            r_err          <= 1'b0;
        end else begin
            r_ic_rsp_valid <= 1'b0;
            r_dc_rsp_valid <= 1'b0;
            if (ic_req_ready) begin
                r_client     <= IC;
                r_last_grant <= IC;
                r_we         <= 1'b0;
                r_addr       <= ic_req_addr;
                r_cnt        <= c_CNT_INIT;
            end else if (dc_req_ready) begin
                r_client     <= DC;
                r_last_grant <= DC;
                r_we         <= dc_req_we;
                r_addr       <= dc_req_addr;
                r_wline      <= dc_req_wline;
                r_cnt        <= c_CNT_INIT;
            end
            if (r_state == WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            // A write ack carries the address only; the read-data line is left intact.
            if (r_state == ISSUE && r_we) begin
                r_dc_rsp_valid <= 1'b1;
                r_dc_rsp_addr  <= r_addr;
            end
            if (r_state == RESP && mem_rec_en) begin
                if (r_client == IC) begin
                    r_ic_rsp_valid <= 1'b1;
                    r_ic_rsp_addr  <= r_addr;
                    r_ic_rsp_line  <= mem_rec_line;
                end else begin
                    r_dc_rsp_valid <= 1'b1;
                    r_dc_rsp_addr  <= r_addr;
                    r_dc_rsp_line  <= mem_rec_line;
                end
            end
            if (mem_rec_en && (r_state != RESP || mem_rec_addr != r_addr)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign ic_rsp_valid = r_ic_rsp_valid;
    assign ic_rsp_addr  = r_ic_rsp_addr;
    assign ic_rsp_line  = r_ic_rsp_line;
    assign dc_rsp_valid = r_dc_rsp_valid;
    assign dc_rsp_addr  = r_dc_rsp_addr;
    assign dc_rsp_line  = r_dc_rsp_line;
    assign mem_raddr    = r_addr;
    assign mem_waddr    = r_addr;
    assign mem_wline    = r_wline;
    assign err          = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed bench for mem_arbiter (LATENCY=5 and LATENCY=0 builds).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    int         vectors = 0;
    int         miscompares = 0;

    logic       ic_req_valid, ic_req_ready, ic_rsp_valid;
    pptr_t      ic_req_addr, ic_rsp_addr;
    cacheline_t ic_rsp_line;
    logic       dc_req_valid, dc_req_we, dc_req_ready, dc_rsp_valid;
    pptr_t      dc_req_addr, dc_rsp_addr;
    cacheline_t dc_req_wline, dc_rsp_line;
    logic       mem_ren, mem_wen, mem_rec_en, err;
    pptr_t      mem_raddr, mem_waddr, mem_rec_addr;
    cacheline_t mem_wline, mem_rec_line;

    logic       z_ic_req_valid, z_ic_req_ready, z_ic_rsp_valid;
    pptr_t      z_ic_req_addr, z_ic_rsp_addr;
    cacheline_t z_ic_rsp_line;
    logic       z_dc_req_ready, z_dc_rsp_valid;
    pptr_t      z_dc_rsp_addr;
    cacheline_t z_dc_rsp_line;
    logic       z_mem_ren, z_mem_wen, z_rec_en, z_err;
    pptr_t      z_mem_raddr, z_mem_waddr, z_rec_addr;
    cacheline_t z_mem_wline, z_rec_line;

    always #5 clk = ~clk;

    mem_arbiter #(.LATENCY(5)) u_dut (
        .clk(clk), .rst(rst),
        .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
        .ic_rsp_valid(ic_rsp_valid), .ic_rsp_addr(ic_rsp_addr), .ic_rsp_line(ic_rsp_line),
        .dc_req_valid(dc_req_valid), .dc_req_we(dc_req_we), .dc_req_addr(dc_req_addr),
        .dc_req_wline(dc_req_wline), .dc_req_ready(dc_req_ready),
        .dc_rsp_valid(dc_rsp_valid), .dc_rsp_addr(dc_rsp_addr), .dc_rsp_line(dc_rsp_line),
        .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_wen(mem_wen),
        .mem_waddr(mem_waddr), .mem_wline(mem_wline),
        .mem_rec_en(mem_rec_en), .mem_rec_addr(mem_rec_addr), .mem_rec_line(mem_rec_line),
        .err(err)
    );

    mem_arbiter #(.LATENCY(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .ic_req_valid(z_ic_req_valid), .ic_req_addr(z_ic_req_addr), .ic_req_ready(z_ic_req_ready),
        .ic_rsp_valid(z_ic_rsp_valid), .ic_rsp_addr(z_ic_rsp_addr), .ic_rsp_line(z_ic_rsp_line),
        .dc_req_valid(1'b0), .dc_req_we(1'b0), .dc_req_addr(32'h0),
        .dc_req_wline(128'h0), .dc_req_ready(z_dc_req_ready),
        .dc_rsp_valid(z_dc_rsp_valid), .dc_rsp_addr(z_dc_rsp_addr), .dc_rsp_line(z_dc_rsp_line),
        .mem_ren(z_mem_ren), .mem_raddr(z_mem_raddr), .mem_wen(z_mem_wen),
        .mem_waddr(z_mem_waddr), .mem_wline(z_mem_wline),
        .mem_rec_en(z_rec_en), .mem_rec_addr(z_rec_addr), .mem_rec_line(z_rec_line),
        .err(z_err)
    );

    // Memory image: every line is a fixed function of its address unless overwritten.
    function automatic cacheline_t img(input pptr_t a);
        return {a, ~a, a ^ 32'h5A5A_5A5A, a + 32'h0000_1234};
    endfunction

    logic       m_rec, inj_rec, w_has;
    pptr_t      corrupt, w_a;
    cacheline_t w_l;

    always @(posedge clk) begin
        m_rec        <= mem_ren;
        mem_rec_addr <= mem_raddr ^ corrupt;
        mem_rec_line <= (w_has && mem_raddr == w_a) ? w_l : img(mem_raddr);
        if (mem_wen) begin
            w_has <= 1'b1;
            w_a   <= mem_waddr;
            w_l   <= mem_wline;
        end
        z_rec_en   <= z_mem_ren;
        z_rec_addr <= z_mem_raddr;
        z_rec_line <= img(z_mem_raddr);
    end
    assign mem_rec_en = m_rec | inj_rec;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    localparam cacheline_t c_LINE_A = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; inj_rec = 1'b0; corrupt = '0; w_has = 1'b0; w_a = '0; w_l = '0; m_rec = 1'b0;
        ic_req_valid = 0; ic_req_addr = '0; dc_req_valid = 0; dc_req_we = 0;
        dc_req_addr = '0; dc_req_wline = '0; z_ic_req_valid = 0; z_ic_req_addr = '0;
        step(); step();
        chk("rst_ic_rsp_valid", ic_rsp_valid, 0);
        chk("rst_dc_rsp_valid", dc_rsp_valid, 0);
        chk("rst_mem_ren", mem_ren, 0);
        chk("rst_mem_wen", mem_wen, 0);
        chk("rst_err", err, 0);
        chk("rst_dc_rsp_line", dc_rsp_line, 0);
        chk("rst_mem_raddr", mem_raddr, 0);
        rst = 1'b0;
        step();

        // Both clients request after reset: DC wins the first tie.
        ic_req_valid = 1; ic_req_addr = 32'h40;
        dc_req_valid = 1; dc_req_we = 0; dc_req_addr = 32'hC0;
        #1;
        chk("tie_dc_ready", dc_req_ready, 1);
        chk("tie_ic_ready", ic_req_ready, 0);
        step();
        dc_req_valid = 0;
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("dcrd_ic_ready_%0d", k), ic_req_ready, (k == 8));
            chk($sformatf("dcrd_dc_rsp_%0d", k), dc_rsp_valid, (k == 8));
            chk($sformatf("dcrd_ic_rsp_%0d", k), ic_rsp_valid, 0);
            chk($sformatf("dcrd_ren_%0d", k), mem_ren, (k == 6));
            if (k < 8) step();
        end
        chk("dcrd_line", dc_rsp_line, img(32'hC0));
        chk("dcrd_addr", dc_rsp_addr, 32'hC0);
        step();
        ic_req_valid = 0;
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("icrd_ren_%0d", k), mem_ren, (k == 6));
            if (k == 6) chk("icrd_raddr", mem_raddr, 32'h40);
            chk($sformatf("icrd_ic_rsp_%0d", k), ic_rsp_valid, (k == 8));
            chk($sformatf("icrd_dc_rsp_%0d", k), dc_rsp_valid, 0);
            if (k < 8) step();
        end
        chk("icrd_line", ic_rsp_line, img(32'h40));
        chk("icrd_addr", ic_rsp_addr, 32'h40);
        chk("icrd_dc_line_hold", dc_rsp_line, img(32'hC0));

        // Writeback then read of the same line.
        dc_req_valid = 1; dc_req_we = 1; dc_req_addr = 32'h100; dc_req_wline = c_LINE_A;
        #1;
        chk("wr_ready", dc_req_ready, 1);
        step();
        dc_req_valid = 0; dc_req_we = 0; dc_req_wline = '0;
        for (int k = 1; k <= 7; k++) begin
            chk($sformatf("wr_wen_%0d", k), mem_wen, (k == 6));
            chk($sformatf("wr_ren_%0d", k), mem_ren, 0);
            chk($sformatf("wr_ack_%0d", k), dc_rsp_valid, (k == 7));
            if (k == 6) begin
                chk("wr_waddr", mem_waddr, 32'h100);
                chk("wr_wline", mem_wline, c_LINE_A);
            end
            if (k < 7) step();
        end
        chk("wr_ack_addr", dc_rsp_addr, 32'h100);
        chk("wr_ack_line_hold", dc_rsp_line, img(32'hC0));
        dc_req_valid = 1; dc_req_addr = 32'h100;
        #1;
        chk("rd_after_wr_ready", dc_req_ready, 1);
        step();
        dc_req_valid = 0;
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("rdaw_rsp_%0d", k), dc_rsp_valid, (k == 8));
            if (k < 8) step();
        end
        chk("rdaw_line", dc_rsp_line, c_LINE_A);
        step();

        // Reset during WAIT drops the transaction.
        ic_req_valid = 1; ic_req_addr = 32'h200;
        #1;
        chk("rw_ready", ic_req_ready, 1);
        step();
        ic_req_valid = 0;
        step();
        rst = 1;
        step();
        rst = 0;
        chk("rw_ic_line_cleared", ic_rsp_line, 0);
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("rw_ren_%0d", k), mem_ren, 0);
            chk($sformatf("rw_ic_rsp_%0d", k), ic_rsp_valid, 0);
            chk($sformatf("rw_dc_rsp_%0d", k), dc_rsp_valid, 0);
            step();
        end
        ic_req_valid = 1; ic_req_addr = 32'h240;
        #1;
        chk("rw_next_ready", ic_req_ready, 1);
        step();
        ic_req_valid = 0;
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("rw_next_rsp_%0d", k), ic_rsp_valid, (k == 8));
            if (k < 8) step();
        end
        chk("rw_next_line", ic_rsp_line, img(32'h240));
        step();

        // Spurious memory response in IDLE sets a sticky error.
        chk("err_pre", err, 0);
        inj_rec = 1;
        step();
        inj_rec = 0;
        chk("err_idle_rec", err, 1);
        step(); step(); step();
        chk("err_sticky", err, 1);
        rst = 1;
        step();
        rst = 0;
        chk("err_rst_clear", err, 0);
        step();

        // Address mismatch in RESP: error raised, line still delivered.
        corrupt = 32'h8;
        ic_req_valid = 1; ic_req_addr = 32'h400;
        #1;
        step();
        ic_req_valid = 0;
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("mm_err_%0d", k), err, (k == 8));
            if (k < 8) step();
        end
        chk("mm_rsp_valid", ic_rsp_valid, 1);
        chk("mm_rsp_line", ic_rsp_line, img(32'h400));
        corrupt = '0;
        step(); step();
        chk("mm_err_sticky", err, 1);
        rst = 1;
        step();
        rst = 0;
        chk("mm_err_rst_clear", err, 0);
        step();

        // LATENCY=0 build.
        z_ic_req_valid = 1; z_ic_req_addr = 32'h300;
        #1;
        chk("l0_ready", z_ic_req_ready, 1);
        step();
        z_ic_req_valid = 0;
        for (int k = 1; k <= 3; k++) begin
            chk($sformatf("l0_ren_%0d", k), z_mem_ren, (k == 1));
            chk($sformatf("l0_rsp_%0d", k), z_ic_rsp_valid, (k == 3));
            if (k < 3) step();
        end
        chk("l0_line", z_ic_rsp_line, img(32'h300));
        chk("l0_err", z_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits directly upstream of the main-memory model.
- Accepts cacheline read requests from the instruction cache and read/write requests from the data cache, and serialises them onto the memory's single request/response interface.
- Inserts a programmable access latency that models DRAM delay.
- Routes each memory response back to the client that issued it.
- Only one transaction is in flight at a time.

Parameters:
- LATENCY, 5, extra wait cycles between request acceptance and the memory request (0 is legal).
- CNT_W, $clog2(LATENCY+1) (minimum 1), width of the latency counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- ic_req_valid  in  1  icache read request
- ic_req_addr  in  pptr_t  icache line address
- ic_req_ready  out  1  icache request accepted this cycle
- ic_rsp_valid  out  1  icache response, single-cycle pulse
- ic_rsp_addr  out  pptr_t  address of the returned line
- ic_rsp_line  out  cacheline_t  returned line
- dc_req_valid  in  1  dcache request
- dc_req_we  in  1  1 = writeback, 0 = read
- dc_req_addr  in  pptr_t  dcache line address
- dc_req_wline  in  cacheline_t  writeback data
- dc_req_ready  out  1  dcache request accepted this cycle
- dc_rsp_valid  out  1  dcache read data or write acknowledge, single-cycle pulse
- dc_rsp_addr  out  pptr_t  response address
- dc_rsp_line  out  cacheline_t  read data; holds its previous value on a write ack
- mem_ren  out  1  to memory req_ren
- mem_raddr  out  pptr_t  to memory req_raddr
- mem_wen  out  1  to memory req_wen
- mem_waddr  out  pptr_t  to memory req_waddr
- mem_wline  out  cacheline_t  to memory req_wcacheline
- mem_rec_en  in  1  from memory rec_en
- mem_rec_addr  in  pptr_t  from memory rec_addr
- mem_rec_line  in  cacheline_t  from memory rec_cacheline
- err  out  1  sticky protocol-error flag

Behaviour:
- Reset:
  - State goes to IDLE; counter = 0.
  - All valid, ready, ren, wen and err outputs = 0; address and line outputs = 0.
  - last_grant = IC, so DC wins the first tie.
  - Reset mid-transaction drops the transaction: no mem_ren/mem_wen and no rsp is issued for it afterwards.
- Handshake:
  - ready is combinational, high only in IDLE and only for the granted client.
  - A transfer happens when valid && ready.
  - A client holds valid, addr, we and wline stable until it is accepted.
- Arbitration, in IDLE:
  - One requester: it is granted.
  - Both requesting: the client other than last_grant wins.
  - last_grant updates on acceptance.
- On acceptance: latch client, we, addr and wline. Next state is WAIT with counter = LATENCY-1, or ISSUE directly if LATENCY = 0.
- WAIT: decrement the counter each cycle; go to ISSUE in the cycle after the counter reads 0.
- ISSUE (one cycle):
  - Read: mem_ren = 1, mem_raddr = latched addr, then go to RESP.
  - Write: mem_wen = 1, mem_waddr/mem_wline = latched values, and register dc_rsp_valid for the next cycle, then go to IDLE.
- RESP: wait for mem_rec_en.
  - On mem_rec_en, register the client's rsp_valid/addr/line (valid next cycle) and go to IDLE.
  - If mem_rec_addr != latched addr, set err; the line is still delivered.
- Timing, with acceptance at edge T:
  - mem_ren high in cycle T+LATENCY+1.
  - mem_rec_en arrives at T+LATENCY+2.
  - rsp_valid high at T+LATENCY+3, which is also the first cycle a new request can be accepted.
  - Write ack: dc_rsp_valid high at T+LATENCY+2; IDLE in the same cycle.
- Single-cycle pulses: rsp_valid, mem_ren and mem_wen are each high for exactly one cycle per transaction.
- err sources: mem_rec_en outside RESP, or an address mismatch. err is cleared only by rst.
- Writes followed by reads to the same line are ordered, because there is only one outstanding transaction.

Decomposition:
- common package:
  - arb_state_t enum {IDLE, WAIT, ISSUE, RESP}
  - client_t enum {IC, DC}
  - default LATENCY constant
  - pptr_t and cacheline_t are already in common.
- Sub-module rr_arbiter2: two requests plus last_grant in, one-hot grant out, combinational.

Test Plan:
- ic read 0x0040, LATENCY=5, accepted at T: mem_ren at T+6 with mem_raddr=0x0040; ic_rsp_valid exactly at T+8 with the memory-image line; dc_rsp_valid stays 0.
- ic and dc reads both valid after reset: dc accepted first; ic accepted at the dc rsp cycle; each response goes only to its own client.
- dc write 0x0100 with line A, then dc read 0x0100: write ack at T+7 with mem_wen pulsed at T+6; the read returns A.
- Reset asserted during WAIT: the next cycles show mem_ren=0 and all rsp_valid=0; the following request completes normally.
- LATENCY=0 build, ic read: mem_ren at T+1, ic_rsp_valid at T+3.
- mem_rec_en forced in IDLE, or rec_addr mismatched in RESP: err=1 and it stays 1 until rst.
